seal_verifier: RTL and testbench



---
 rtl/seal_pkg.sv | 30 +++
 rtl/seal_verifier_if.sv | 24 ++
 rtl/seal_record_shifter.sv | 31 +++
 rtl/seal_verifier.sv | 132 +++++++++++++
 tb/tb_seal_verifier.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/seal_pkg.sv
// seal_pkg: shared FSM states, record geometry, register map and STATUS bit positions
package seal_pkg;
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INIT  = 3'd1,
        S_FEED  = 3'd2,
        S_WAIT  = 3'd3,
        S_CHECK = 3'd4
    } state_t;

    localparam int REC_BYTES = 9;

    localparam logic [1:0] WA_PAYLOAD = 2'd0;
    localparam logic [1:0] WA_MONO    = 2'd1;
    localparam logic [1:0] WA_TAG     = 2'd2;
    localparam logic [1:0] WA_CTRL    = 2'd3;

    localparam logic [1:0] RA_STATUS    = 2'd0;
    localparam logic [1:0] RA_LAST_MONO = 2'd1;
    localparam logic [1:0] RA_SESSION   = 2'd2;

    localparam int ST_BUSY     = 0;
    localparam int ST_DONE     = 1;
    localparam int ST_PASS     = 2;
    localparam int ST_CRC_ERR  = 3;
    localparam int ST_REPLAY   = 4;
    localparam int ST_SESSION  = 5;
    localparam int ST_DROPPED  = 6;
    localparam int ST_HISTORY  = 7;
endpackage

// File: rtl/seal_verifier_if.sv
// seal_verifier_if: peripheral bus, shared CRC engine port and verdict outputs
interface seal_verifier_if;
    logic        wr_en;
    logic [1:0]  wr_addr;
    logic [31:0] wr_data;
    logic [1:0]  rd_addr;
    logic [31:0] rd_data;
    logic        crc_init;
    logic [7:0]  crc_byte;
    logic        crc_feed;
    logic        crc_busy;
    logic [15:0] crc_value;
    logic        verdict_valid;
    logic        verdict_pass;

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_addr, crc_busy, crc_value,
        output rd_data, crc_init, crc_byte, crc_feed, verdict_valid, verdict_pass
    );
    modport master (
        output wr_en, wr_addr, wr_data, rd_addr, crc_busy, crc_value,
        input  rd_data, crc_init, crc_byte, crc_feed, verdict_valid, verdict_pass
    );
endinterface

// File: rtl/seal_record_shifter.sv
// seal_record_shifter: record snapshot presented MSB byte first, with remaining-byte count
module seal_record_shifter
    import seal_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   load,
    input  logic                   shift,
    input  logic [REC_BYTES*8-1:0] din,
    output logic [7:0]             cur_byte,
    output logic                   last
);
    logic [REC_BYTES*8-1:0] sr;
    logic [3:0]             cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr  <= '0;
            cnt <= '0;
        end else if (load) begin
            sr  <= din;
            cnt <= 4'(REC_BYTES);
        end else if (shift) begin
            sr  <= {sr[REC_BYTES*8-9:0], 8'h00};
            cnt <= cnt - 4'd1;
        end
    end

    assign cur_byte = sr[REC_BYTES*8-1 -: 8];
    assign last     = cnt == 4'd1;
endmodule

// File: rtl/seal_verifier.sv
// seal_verifier: recomputes a sealed record's CRC16 and checks CRC, monotonic count and session binding
module seal_verifier
    import seal_pkg::*;
#(
    parameter int PASS_CTR_W = 16,
    parameter int FAIL_CTR_W = 8
) (
    input logic           clk,
    input logic           rst_n,
    seal_verifier_if.slave bus
);
    state_t                state, state_nx;
    logic [31:0]           payload, mono, last_mono, status;
    logic [23:0]           tag;
    logic [15:0]           crc_q;
    logic [7:0]            bound_session, sh_byte;
    logic [2:0]            err, err_q, err_now;
    logic                  bound, hist, done, pass, vp_q, start_dropped, last_fed, sh_last;
    logic                  idle, ctrl_wr, start, clear, feed, finish;
    logic [PASS_CTR_W-1:0] pass_cnt;
    logic [FAIL_CTR_W-1:0] fail_cnt;

    assign idle    = state == S_IDLE;
    assign ctrl_wr = bus.wr_en && bus.wr_addr == WA_CTRL;
    assign start   = ctrl_wr && bus.wr_data[0];
    assign clear   = ctrl_wr && bus.wr_data[1];
    assign feed    = state == S_FEED && !bus.crc_busy;
    assign finish  = state == S_WAIT && !bus.crc_busy && last_fed;
    // {session, replay, crc}; sampled when the last byte has settled in the engine
    assign err_now = {bound && tag[23:16] != bound_session,
                      hist && mono <= last_mono,
                      bus.crc_value != tag[15:0]};

    always_comb
        state_nx = idle            ? (start ? S_INIT : S_IDLE) :
                   state == S_INIT ? S_FEED :
                   state == S_FEED ? (bus.crc_busy ? S_FEED : S_WAIT) :
                   state == S_WAIT ? (bus.crc_busy ? S_WAIT : last_fed ? S_CHECK : S_FEED) :
                   S_IDLE;

    seal_record_shifter u_shift (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (idle && start),
        .shift    (feed),
        .din      ({payload, mono, tag[23:16]}),
        .cur_byte (sh_byte),
        .last     (sh_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            payload       <= '0;
            mono          <= '0;
            tag           <= '0;
            last_mono     <= '0;
            crc_q         <= '0;
            bound_session <= '0;
            err           <= '0;
            err_q         <= '0;
            bound         <= 1'b0;
            hist          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            vp_q          <= 1'b0;
            start_dropped <= 1'b0;
            last_fed      <= 1'b0;
            pass_cnt      <= '0;
            fail_cnt      <= '0;
        end else begin
            state <= state_nx;
            if (idle && bus.wr_en && bus.wr_addr == WA_PAYLOAD) payload <= bus.wr_data;
            if (idle && bus.wr_en && bus.wr_addr == WA_MONO) mono <= bus.wr_data;
            if (idle && bus.wr_en && bus.wr_addr == WA_TAG) tag <= bus.wr_data[23:0];
            if (idle && clear) begin
                hist      <= 1'b0;
                last_mono <= '0;
                bound     <= 1'b0;
            end
            if (idle && start) begin
                done <= 1'b0;
                pass <= 1'b0;
                err  <= '0;
            end
            if (!idle && start) start_dropped <= 1'b1;
            if (feed) last_fed <= sh_last;
            if (finish) begin
                err_q <= err_now;
                vp_q  <= ~|err_now;
                crc_q <= bus.crc_value;
            end
            if (state == S_CHECK) begin
                done <= 1'b1;
                pass <= vp_q;
                err  <= err_q;
                if (vp_q) begin
                    last_mono <= mono;
                    hist      <= 1'b1;
                    bound     <= 1'b1;
                    if (!bound) bound_session <= tag[23:16];
                    pass_cnt  <= pass_cnt + PASS_CTR_W'(~&pass_cnt);
                end else begin
                    fail_cnt  <= fail_cnt + FAIL_CTR_W'(~&fail_cnt);
                end
            end
        end
    end

    always_comb begin
        status              = '0;
        status[ST_BUSY]     = !idle;
        status[ST_DONE]     = done;
        status[ST_PASS]     = pass;
        status[ST_CRC_ERR]  = err[0];
        status[ST_REPLAY]   = err[1];
        status[ST_SESSION]  = err[2];
        status[ST_DROPPED]  = start_dropped;
        status[ST_HISTORY]  = hist;
        status[15:8]        = 8'(fail_cnt);
        status[31:16]       = 16'(pass_cnt);
    end

    assign bus.rd_data       = bus.rd_addr == RA_STATUS    ? status :
                               bus.rd_addr == RA_LAST_MONO ? last_mono :
                               bus.rd_addr == RA_SESSION   ? {8'h00, bound_session, crc_q} : '0;
    assign bus.crc_init      = state == S_INIT;
    assign bus.crc_feed      = feed;
    assign bus.crc_byte      = sh_byte;
    assign bus.verdict_valid = state == S_CHECK;
    assign bus.verdict_pass  = vp_q;
endmodule

// File: tb/tb_seal_verifier.sv
// tb_seal_verifier: random and directed records against a behavioural model, with a stalling CRC16 engine model
module tb_seal_verifier;
    import seal_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   stall = 0;
    int   bcnt = 0;
    int   vcount = 0;
    int   feeds = 0;
    int   viol = 0;
    int   m_verd = 0;
    logic [15:0] eng_crc;

    logic [31:0] m_last;
    logic [15:0] m_pc;
    logic [7:0]  m_fc, m_bsess;
    logic        m_hist, m_bound, m_sdrop;

    seal_verifier_if bus();

    seal_verifier #(.PASS_CTR_W(16), .FAIL_CTR_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c ^ {b, 8'h00};
        for (int k = 0; k < 8; k++) r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
        return r;
    endfunction

    function automatic logic [15:0] golden(input logic [31:0] p, input logic [31:0] m, input logic [7:0] s);
        logic [15:0] r;
        r = 16'hFFFF;
        for (int i = 0; i < 4; i++) r = crc_upd(r, p[31-8*i -: 8]);
        for (int i = 0; i < 4; i++) r = crc_upd(r, m[31-8*i -: 8]);
        return crc_upd(r, s);
    endfunction

    // CRC16-CCITT engine: busy for `stall` cycles after every init and every byte
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eng_crc <= 16'h0000;
            bcnt    <= 0;
        end else if (bus.crc_init) begin
            eng_crc <= 16'hFFFF;
            bcnt    <= stall;
        end else if (bus.crc_feed) begin
            eng_crc <= crc_upd(eng_crc, bus.crc_byte);
            bcnt    <= stall;
        end else if (bcnt != 0) begin
            bcnt <= bcnt - 1;
        end
    end
    assign bus.crc_busy  = bcnt != 0;
    assign bus.crc_value = eng_crc;

    always @(posedge clk) begin
        if (bus.verdict_valid) vcount <= vcount + 1;
        if (bus.crc_feed) feeds <= feeds + 1;
        if ((bus.crc_feed && bus.crc_busy) || (bus.crc_feed && bus.crc_init)) viol <= viol + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_addr = a;
        bus.wr_data = d;
        @(posedge clk);
        #1 bus.wr_en = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        bus.rd_addr = a;
        #1 d = bus.rd_data;
    endtask

    task automatic model_reset();
        m_last = '0; m_pc = '0; m_fc = '0; m_bsess = '0;
        m_hist = 1'b0; m_bound = 1'b0; m_sdrop = 1'b0;
    endtask

    task automatic run_rec(input logic [31:0] p, input logic [31:0] m, input logic [7:0] s,
                           input logic [15:0] c, input logic clr, input int dup, input int st);
        logic [15:0] g;
        logic [31:0] d;
        logic ec, er, es, ep, got, vp;
        int lat;
        stall = st;
        g = golden(p, m, s);
        bus_wr(WA_PAYLOAD, p);
        bus_wr(WA_MONO, m);
        bus_wr(WA_TAG, {8'h00, s, c});
        bus_wr(WA_CTRL, {30'h0, clr, 1'b1});
        if (clr) begin m_hist = 1'b0; m_last = '0; m_bound = 1'b0; end
        ec = c != g;
        er = m_hist && m <= m_last;
        es = m_bound && s != m_bsess;
        ep = !(ec || er || es);
        got = 1'b0; vp = 1'b0; lat = 0;
        for (int i = 1; i <= 300 && !got; i++) begin
            @(negedge clk);
            // mid-check: a second start, a mono overwrite and a clear must all be ignored
            bus.wr_en   = dup != 0 && i >= dup && i <= dup + 2;
            bus.wr_addr = i == dup + 1 ? WA_MONO : WA_CTRL;
            bus.wr_data = i == dup ? 32'h1 : i == dup + 1 ? 32'h0 : 32'h2;
            if (i == 3) begin
                rd(RA_STATUS, d);
                chk("busy_flags", 32'(d[5:0]), 32'h01);
                chk("hist_at_start", 32'(d[7]), 32'(m_hist));
            end
            if (bus.verdict_valid) begin got = 1'b1; lat = i; vp = bus.verdict_pass; end
        end
        bus.wr_en = 1'b0;
        chk("verdict_seen", 32'(got), 32'h1);
        if (st == 0) chk("latency", lat, 20);
        chk("verdict_pass", 32'(vp), 32'(ep));
        if (ep) begin
            m_last = m; m_hist = 1'b1;
            if (!m_bound) begin m_bound = 1'b1; m_bsess = s; end
            if (m_pc != 16'hFFFF) m_pc++;
        end else if (m_fc != 8'hFF) m_fc++;
        if (dup != 0) m_sdrop = 1'b1;
        m_verd++;
        @(negedge clk);
        rd(RA_STATUS, d);
        chk("status", d, {m_pc, m_fc, m_hist, m_sdrop, es, er, ec, ep, 1'b1, 1'b0});
        rd(RA_LAST_MONO, d);
        chk("last_mono", d, m_last);
        rd(RA_SESSION, d);
        chk("session_crc", d, {8'h00, m_bsess, g});
        repeat (2) @(negedge clk);
        chk("verdict_count", vcount, m_verd);
        chk("verdict_hold", 32'(bus.verdict_pass), 32'(ep));
    endtask

    task automatic reset_mid();
        int base;
        logic [31:0] d;
        stall = 0;
        base = feeds;
        bus_wr(WA_PAYLOAD, 32'h1234_5678);
        bus_wr(WA_MONO, m_last + 1);
        bus_wr(WA_TAG, {8'h00, m_bsess, 16'h0});
        bus_wr(WA_CTRL, 32'h1);
        for (int i = 0; i < 100 && feeds - base < 4; i++) @(negedge clk);
        chk("feeds_before_rst", feeds - base, 4);
        rst_n = 1'b0;
        rd(RA_STATUS, d);
        chk("rst_status", d, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_feed_init", {30'h0, bus.crc_feed, bus.crc_init}, 32'h0);
        rd(RA_STATUS, d);
        chk("rst_status_after", d, 32'h0);
        rd(RA_LAST_MONO, d);
        chk("rst_last_mono", d, 32'h0);
        rd(RA_SESSION, d);
        chk("rst_session", d, 32'h0);
        repeat (30) @(negedge clk);
        chk("rst_no_verdict", vcount, m_verd);
        model_reset();
    endtask

    initial begin
        logic [31:0] d, p, m;
        logic [15:0] g, c;
        logic [7:0]  s;
        logic        clr;
        int          r, dup;
        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0; bus.rd_addr = '0;
        model_reset();
        repeat (3) @(negedge clk);
        rd(RA_STATUS, d);
        chk("reset_status", d, 32'h0);
        chk("reset_outs", {27'h0, bus.crc_init, bus.crc_feed, bus.verdict_valid, bus.verdict_pass, 1'b0}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        run_rec(32'hDEADBEEF, 32'd5, 8'h3C, golden(32'hDEADBEEF, 32'd5, 8'h3C), 1'b0, 0, 0);
        run_rec(32'hDEADBEEF, 32'd5, 8'h3C, golden(32'hDEADBEEF, 32'd5, 8'h3C), 1'b0, 0, 0);
        run_rec(32'hDEADBEEF, 32'd6, 8'h3C, golden(32'hDEADBEEF, 32'd6, 8'h3C), 1'b0, 0, 0);
        run_rec(32'hCAFEF00D, 32'd7, 8'h3C, golden(32'hCAFEF00D, 32'd7, 8'h3C) ^ 16'h0001, 1'b0, 0, 0);
        run_rec(32'h0BADC0DE, 32'd8, 8'h3D, golden(32'h0BADC0DE, 32'd8, 8'h3D), 1'b0, 0, 0);
        run_rec(32'h0BADC0DE, 32'd8, 8'h3D, golden(32'h0BADC0DE, 32'd8, 8'h3D), 1'b1, 0, 0);
        run_rec(32'h13579BDF, 32'd9, 8'h3D, golden(32'h13579BDF, 32'd9, 8'h3D), 1'b0, 5, 3);
        chk("no_feed_while_busy", viol, 0);
        run_rec(32'h2468ACE0, 32'hFFFF_FFFF, 8'h3D, golden(32'h2468ACE0, 32'hFFFF_FFFF, 8'h3D), 1'b0, 0, 1);
        run_rec(32'h2468ACE1, 32'h0, 8'h3D, golden(32'h2468ACE1, 32'h0, 8'h3D), 1'b0, 0, 0);
        bus.rd_addr = 2'd3;
        #1 chk("rd_addr3", bus.rd_data, 32'h0);

        for (int n = 0; n < 25; n++) begin
            p = $urandom;
            r = $urandom_range(0, 4);
            m = r == 0 ? m_last : r == 1 ? m_last - 1 : r == 2 ? $urandom : m_last + 32'(r);
            clr = m_last == 32'hFFFF_FFFF || $urandom_range(0, 7) == 0;
            s = $urandom_range(0, 2) == 0 ? 8'($urandom) : m_bsess;
            g = golden(p, m, s);
            c = $urandom_range(0, 4) == 0 ? g ^ (16'h1 << $urandom_range(0, 15)) : g;
            dup = $urandom_range(0, 5) == 0 ? $urandom_range(1, 15) : 0;
            run_rec(p, m, s, c, clr, dup, $urandom_range(0, 3));
        end

        reset_mid();
        run_rec(32'h0000_0001, 32'h0, 8'h77, golden(32'h0000_0001, 32'h0, 8'h77), 1'b0, 0, 0);
        run_rec(32'h0000_0002, 32'h0, 8'h77, golden(32'h0000_0002, 32'h0, 8'h77), 1'b0, 0, 2);
        chk("no_feed_while_busy_end", viol, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
